// File: rtl/lsu.sv
// Load/store unit for the RV32I memory stage: one outstanding valid/ready
// transaction on the data port, store lane steering and load extension.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_valid,
    output logic            exc_is_store,
    output logic [XLEN-1:0] exc_addr,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_next;
    logic              accept, misaligned, rsp_take;
    logic [XLEN-1:0]   addr_q, data_q, lane, load_ext;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              store_q;

    assign accept   = ex_valid && ex_ready && (ex_is_load || ex_is_store);
    assign rsp_take = (state == WAIT) && dmem_rsp_valid;

    // funct3[1:0]==11 falls into the word case, like 10.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_addr[0];
            default: misaligned = |ex_addr[1:0];
        endcase
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: the default assignment first keeps this combinational block latch-free.
        state_next = state;
        case (state)
            IDLE:    if (accept && !misaligned) state_next = REQ;
            REQ:     if (dmem_req_ready) state_next = store_q ? IDLE : WAIT;
            WAIT:    if (dmem_rsp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ex_ready       = (state == IDLE) && !rst;
        busy           = (state != IDLE);
        dmem_req_valid = (state == REQ);
        dmem_we        = (state == REQ) && store_q;
        dmem_wstrb     = 4'b0000;
        if ((state == REQ) && store_q) begin
            case (funct3_q[1:0])
                2'b00:   dmem_wstrb = 4'b0001 << addr_q[1:0];
                2'b01:   dmem_wstrb = 4'b0011 << addr_q[1:0];
                default: dmem_wstrb = 4'b1111;
            endcase
        end
    end

    assign dmem_addr = {addr_q[XLEN-1:2], 2'b00};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   dmem_wdata = {4{data_q[7:0]}};
            2'b01:   dmem_wdata = {2{data_q[15:0]}};
            default: dmem_wdata = data_q;
        endcase
    end

    // Load extraction: bring the addressed byte/half down to lane 0, then extend.
    assign lane = dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_ext = funct3_q[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_ext = funct3_q[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            data_q       <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            store_q      <= 1'b0;
            exc_valid    <= 1'b0;
            exc_is_store <= 1'b0;
            exc_addr     <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            if (accept && !misaligned) begin
                addr_q   <= ex_addr;
                data_q   <= ex_store_data;
                funct3_q <= ex_funct3;
                rd_q     <= ex_rd;
                store_q  <= ex_is_store;
            end
            exc_valid <= accept && misaligned;
            if (accept && misaligned) begin
                exc_addr     <= ex_addr;
                exc_is_store <= ex_is_store;
            end
            wb_valid <= rsp_take;
            if (rsp_take) begin
                wb_data <= load_ext;
                wb_rd   <= rd_q;
            end
        end
    end

endmodule
